ram_target: RTL
===============

RAM_TARGET -- requirements
Module: ram_target

Interface
REQ-001 Parameter DEPTH, default 1024, RAM depth in 32-bit words; power of two, at least 2.
REQ-002 Parameter LATENCY, default 1, wait-state cycles between request acceptance and RAM access; range 0..15.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 m_address  input  32  byte address of request.
REQ-006 m_data  input  32  write data.
REQ-007 m_write  input  1  1 = write, 0 = read.
REQ-008 m_valid  input  1  request valid from core.
REQ-009 m_ready  output  1  request accepted when m_valid && m_ready at a rising edge.
REQ-010 s_data  output  32  read response data.
REQ-011 s_valid  output  1  response valid.
REQ-012 s_ready  input  1  response consumed when s_valid && s_ready at a rising edge.
REQ-013 err  output  1  sticky out-of-range flag (see Configuration).

Function
REQ-014 Word index = m_address[log2(DEPTH)+1:2]; m_address[1:0] ignored.
REQ-015 FSM states IDLE, BUSY; IDLE->BUSY on acceptance; BUSY->IDLE after access cycle; one request outstanding at most.
REQ-016 Request fields latched at acceptance; later changes on m_* inputs do not affect it.
REQ-017 Acceptance at edge T -> RAM access at edge T+1+LATENCY; BUSY for exactly 1+LATENCY cycles.
REQ-018 Writes update RAM at access edge; writes produce no response.
REQ-019 Reads push RAM word into 2-entry response FIFO at access edge; s_valid high from the following cycle.
REQ-020 m_ready = (state == IDLE) && (FIFO count < 2); combinational from registered state only, not from m_valid.
REQ-021 s_valid = FIFO not empty; s_data = FIFO head; both held stable while s_valid && !s_ready.
REQ-022 Push and pop on the same edge: count unchanged, order preserved.
REQ-023 Responses return in request order; a read after a write to the same word returns the written data.
REQ-024 m_valid low while m_ready high: no state change.
REQ-025 Read of never-written word returns undefined value; bench does not check it.

Reset
REQ-026 reset low: state = IDLE, FIFO empty, s_valid = 0, err = 0, s_data = 0, m_ready = 1 immediately after release.
REQ-027 reset asserted mid-BUSY aborts the request: pending write not committed, pending read not returned.
REQ-028 RAM contents not cleared by reset.

Configuration
REQ-029 Macro RAM_TARGET_ERR_EN defined: request with m_address[31:log2(DEPTH)+2] nonzero is out-of-range; write dropped, read returns 32'hDEADBEEF with normal latency, err set to 1 at access edge and held until reset.
REQ-030 RAM_TARGET_ERR_EN undefined: upper address bits ignored (address wraps modulo DEPTH words); err tied 0.

Verification
REQ-031 LATENCY=1: write 0x12345678 to 0x10 accepted at edge T, read 0x10 -> m_ready low edges T+1..T+2, s_valid with s_data=0x12345678 two cycles after read acceptance.
REQ-032 s_ready held 0, three back-to-back reads -> two responses buffered, m_ready low with count=2; s_ready high -> responses drain in order, third read accepted.
REQ-033 s_ready=1 continuously, reads streaming -> push/pop same edge, s_valid asserted one cycle per read, no stall beyond LATENCY.
REQ-034 reset asserted in BUSY of write 0xAAAA5555 to 0x20 -> after release read 0x20 does not return 0xAAAA5555 (prior value 0x0 written before reset retained); s_valid=0 during reset.
REQ-035 RAM_TARGET_ERR_EN, DEPTH=1024: read 0x0000_1000 -> s_data=0xDEADBEEF, err=1 and stays 1; undefined: same read returns word 0 contents, err=0.

Source files
------------

// File: rtl/ram_target.sv
// Single-port word RAM target: request/response handshake, programmable wait states, 2-entry read FIFO.
// Optional macro RAM_TARGET_ERR_EN flags out-of-range addresses (sticky err, 32'hDEADBEEF read data).
module ram_target #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] m_address,
    input  logic [31:0] m_data,
    input  logic        m_write,
    input  logic        m_valid,
    output logic        m_ready,
    output logic [31:0] s_data,
    output logic        s_valid,
    input  logic        s_ready,
    output logic        err
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [3:0]  LAT = 4'(LATENCY);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [3:0]      wait_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     data_q;
    logic            write_q;
    logic            oor_q;
    logic            req_oor;
    logic            accept, access, push, pop;
    logic [31:0]     rd_word;
    logic [31:0]     mem [DEPTH];
    logic [31:0]     fifo_q [2];
    logic            rd_ptr_q, wr_ptr_q;
    logic [1:0]      count_q;
    logic            unused_addr_bits;

`ifdef RAM_TARGET_ERR_EN
    logic err_q;

    assign req_oor          = |m_address[31:AW+2];
    assign unused_addr_bits = ^m_address[1:0];
    assign err              = err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            err_q <= 1'b0;
        else if (access && oor_q)
            err_q <= 1'b1;
    end
`else
    assign req_oor          = 1'b0;
    assign unused_addr_bits = ^{m_address[31:AW+2], m_address[1:0]};
    assign err              = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        m_ready = 1'b0;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                m_ready = (count_q < 2'd2);
                if (m_valid && m_ready) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (wait_q == LAT) begin
                    access  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                wait_q <= '0;
            else if (state_q == BUSY)
                wait_q <= wait_q + 4'd1;
        end
    end

    // Request fields are captured once so later m_* activity cannot disturb the access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            oor_q   <= 1'b0;
        end else if (accept) begin
            idx_q   <= m_address[AW+1:2];
            data_q  <= m_data;
            write_q <= m_write;
            oor_q   <= req_oor;
        end
    end

    // Storage has no reset; an aborted request never reaches access because reset forces IDLE.
    always_ff @(posedge clock) begin
        if (access && write_q && !oor_q)
            mem[idx_q] <= data_q;
    end

    assign rd_word = oor_q ? 32'hDEAD_BEEF : mem[idx_q];
    assign push    = access && !write_q;
    assign pop     = s_valid && s_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= rd_word;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign s_valid = (count_q != 2'd0);
    assign s_data  = fifo_q[rd_ptr_q];

endmodule
